// File: rtl/nfca_rx_defs_pkg.sv
// Shared definitions for the NFC-A PICC->PCD receive frame decoder:
// parameter defaults, FSM state codes, half-bit pair codes, parity helper.
package nfca_rx_defs;

  localparam int HALF_SAMPLES_DEF = 8;
  localparam int HALF_TH_DEF      = 4;
  localparam int MAX_BYTES_DEF    = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SOF   = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // {first_half, second_half}
  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;
  localparam logic [1:0] PAIR_END  = 2'b00;
  localparam logic [1:0] PAIR_COL  = 2'b11;

  // Expected parity bit so that data plus parity has an odd count of ones.
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/nfca_rx_half_slicer.sv
// Half-bit slicer: counts HALF_SAMPLES strobed samples and majority-votes them.
// Ports: clr (sync clear), smp_en/smp (sample), half_en/half_val (comb, on closing sample).
module nfca_rx_half_slicer
  import nfca_rx_defs::*;
#(
  parameter int HALF_SAMPLES = HALF_SAMPLES_DEF,
  parameter int HALF_TH      = HALF_TH_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic smp_en,
  input  logic smp,
  output logic half_en,
  output logic half_val
);

  localparam int CW = (HALF_SAMPLES > 1) ? $clog2(HALF_SAMPLES) : 1;
  localparam int AW = $clog2(HALF_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_SAMPLES - 1);
  localparam logic [AW-1:0] TH = AW'(HALF_TH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] acc_nx;

  // The closing sample is included in the vote, so the
  // decision is available in the same clk as its strobe.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    half_en  = 1'b0;
    half_val = 1'b0;
    acc_nx   = acc_q + AW'(smp);
    if (clr) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (smp_en) begin
      if (cnt_q == CNT_LAST) begin
        half_en  = 1'b1;
        half_val = (acc_nx >= TH);
        cnt_d    = '0;
        acc_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = acc_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/nfca_rx_frame_decoder.sv
// NFC-A PICC->PCD Manchester frame decoder: half-bit pairs -> LSB-first bytes + frame end.
// In: rx_on, rx_ask_en, rx_ask. Out: rx_byte_en/rx_byte/rx_byte_bits, rx_end/_err/_col, rx_busy.
// Option NFCA_RX_COLLISION_EN: collision pair decodes as 1 and sets col instead of ending the frame.
module nfca_rx_frame_decoder
  import nfca_rx_defs::*;
#(
  parameter int HALF_SAMPLES = HALF_SAMPLES_DEF,
  parameter int HALF_TH      = HALF_TH_DEF,
  parameter int MAX_BYTES    = MAX_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_on,
  input  logic       rx_ask_en,
  input  logic       rx_ask,
  output logic       rx_byte_en,
  output logic [7:0] rx_byte,
  output logic [3:0] rx_byte_bits,
  output logic       rx_end,
  output logic       rx_end_err,
  output logic       rx_end_col,
  output logic       rx_busy
);

  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [BW-1:0] NB_MAX = BW'(MAX_BYTES);

  logic [1:0]    state_q, state_d;
  logic          hsec_q, hsec_d;
  logic          hval_q, hval_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    idx_q, idx_d;
  logic [BW-1:0] nbytes_q, nbytes_d;
  logic          err_q, err_d;
  logic          col_q, col_d;

  logic          byte_en_q, byte_en_d;
  logic [7:0]    byte_q, byte_d;
  logic [3:0]    bits_q, bits_d;
  logic          end_q, end_d;
  logic          end_err_q, end_err_d;
  logic          end_col_q, end_col_d;
  logic          busy_q, busy_d;

  logic          slc_en;
  logic          half_en;
  logic          half_val;

  logic [1:0]    pair;
  logic          bitv;
  logic          is_end;
  logic          is_col;
  logic          col_hit;
  logic          stop_col;
  logic          par_bad;
  logic [7:0]    data_nx;

  // Slicing starts on the very sample that opens the frame.
  assign slc_en = rx_on & rx_ask_en &
                  ((state_q == ST_SOF) |
                   (state_q == ST_DATA) |
                   ((state_q == ST_IDLE) & rx_ask));

  nfca_rx_half_slicer #(
    .HALF_SAMPLES (HALF_SAMPLES),
    .HALF_TH      (HALF_TH)
  ) u_slicer (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (~rx_on),
    .smp_en   (slc_en),
    .smp      (rx_ask),
    .half_en  (half_en),
    .half_val (half_val)
  );

  always_comb begin
    state_d   = state_q;
    hsec_d    = hsec_q;
    hval_d    = hval_q;
    data_d    = data_q;
    idx_d     = idx_q;
    nbytes_d  = nbytes_q;
    err_d     = err_q;
    col_d     = col_q;
    byte_en_d = 1'b0;
    byte_d    = byte_q;
    bits_d    = bits_q;
    end_d     = 1'b0;
    end_err_d = 1'b0;
    end_col_d = 1'b0;

    pair    = {hval_q, half_val};
    bitv    = pair[1];
    is_end  = (pair == PAIR_END);
    is_col  = (pair == PAIR_COL);
`ifdef NFCA_RX_COLLISION_EN
    col_hit  = is_col;
    stop_col = 1'b0;
`else
    col_hit  = 1'b0;
    stop_col = is_col;
`endif
    data_nx = data_q;
    data_nx[idx_q[2:0]] = bitv;
    par_bad = (bitv != odd_par(data_q));

    if (!rx_on) begin
      state_d  = ST_IDLE;
      hsec_d   = 1'b0;
      data_d   = '0;
      idx_d    = '0;
      nbytes_d = '0;
      err_d    = 1'b0;
      col_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_ask_en && rx_ask) begin
            state_d  = ST_SOF;
            hsec_d   = 1'b0;
            data_d   = '0;
            idx_d    = '0;
            nbytes_d = '0;
            err_d    = 1'b0;
            col_d    = 1'b0;
          end
        end
        ST_SOF: begin
          if (half_en) begin
            if (!hsec_q) begin
              hsec_d = 1'b1;
              hval_d = half_val;
            end else begin
              hsec_d  = 1'b0;
              state_d = (pair == PAIR_ONE) ? ST_DATA : ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (half_en) begin
            if (!hsec_q) begin
              hsec_d = 1'b1;
              hval_d = half_val;
            end else begin
              hsec_d = 1'b0;
              if (is_end) begin
                if (idx_q != 4'd0) begin
                  byte_en_d = 1'b1;
                  byte_d    = data_q;
                  bits_d    = idx_q;
                  state_d   = ST_FLUSH;
                end else begin
                  end_d     = 1'b1;
                  end_err_d = err_q;
                  end_col_d = col_q;
                  state_d   = ST_IDLE;
                end
              end else if (nbytes_q == NB_MAX) begin
                // One bit beyond the byte budget aborts the frame.
                end_d     = 1'b1;
                end_err_d = 1'b1;
                end_col_d = col_q | col_hit;
                state_d   = ST_IDLE;
              end else begin
                col_d = col_q | col_hit;
                if (idx_q == 4'd8) begin
                  byte_en_d = 1'b1;
                  byte_d    = data_q;
                  bits_d    = 4'd8;
                  idx_d     = '0;
                  data_d    = '0;
                  nbytes_d  = nbytes_q + 1'b1;
                  err_d     = err_q | par_bad;
                end else begin
                  data_d = data_nx;
                  idx_d  = idx_q + 4'd1;
                end
                // Collision without support: keep the bit, then end like END.
                if (stop_col) begin
                  err_d   = 1'b1;
                  state_d = ST_FLUSH;
                  if (idx_q != 4'd8) begin
                    byte_en_d = 1'b1;
                    byte_d    = data_nx;
                    bits_d    = idx_q + 4'd1;
                  end
                end
              end
            end
          end
        end
        ST_FLUSH: begin
          end_d     = 1'b1;
          end_err_d = err_q;
          end_col_d = col_q;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_DATA) | (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      hsec_q    <= 1'b0;
      hval_q    <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
      nbytes_q  <= '0;
      err_q     <= 1'b0;
      col_q     <= 1'b0;
      byte_en_q <= 1'b0;
      byte_q    <= '0;
      bits_q    <= '0;
      end_q     <= 1'b0;
      end_err_q <= 1'b0;
      end_col_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hsec_q    <= hsec_d;
      hval_q    <= hval_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      nbytes_q  <= nbytes_d;
      err_q     <= err_d;
      col_q     <= col_d;
      byte_en_q <= byte_en_d;
      byte_q    <= byte_d;
      bits_q    <= bits_d;
      end_q     <= end_d;
      end_err_q <= end_err_d;
      end_col_q <= end_col_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_byte_en   = byte_en_q;
  assign rx_byte      = byte_q;
  assign rx_byte_bits = bits_q;
  assign rx_end       = end_q;
  assign rx_end_err   = end_err_q;
  assign rx_busy      = busy_q;
`ifdef NFCA_RX_COLLISION_EN
  assign rx_end_col   = end_col_q;
`else
  assign rx_end_col   = 1'b0;
`endif

endmodule
